// File: rtl/freq_divide_ctrl.sv
// freq_divide_ctrl: programmable tick / square-wave enable sequencer.
// Divisor and burst are loaded in IDLE; RUN emits a tick every D cycles.
module freq_divide_ctrl #(
    parameter int DIV_W       = 24,
    parameter int BURST_W     = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [DIV_W-1:0]   cfg_div,
    input  logic [BURST_W-1:0] cfg_burst,
    input  logic               start,
    input  logic               stop,
    output logic               tick,
    output logic               out_clk,
    output logic [BURST_W-1:0] tick_cnt,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [BURST_W-1:0] tcnt_q, tcnt_d;
    logic               tick_q, tick_d;
    logic               oclk_q, oclk_d;
    logic               done_q, done_d;
    logic [DIV_W-1:0]   d_run;
    logic [DIV_W-1:0]   d_new;
    logic               last;

    // A zero divisor behaves as a divide-by-one.
    function automatic logic [DIV_W-1:0] eff(input logic [DIV_W-1:0] v);
        return (v == '0) ? DIV_W'(1) : v;
    endfunction

    assign d_run     = eff(div_q);
    assign cfg_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign tick      = tick_q;
    assign out_clk   = oclk_q;
    assign tick_cnt  = tcnt_q;
    assign done      = done_q;

    // Next-state and next-register values; tick is scheduled one edge
    // ahead so it is visible in the cycle where the counter hits D-1.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        burst_d = burst_q;
        cnt_d   = cnt_q;
        tcnt_d  = tcnt_q;
        tick_d  = 1'b0;
        oclk_d  = oclk_q;
        done_d  = 1'b0;
        d_new   = '0;
        last    = 1'b0;
        unique case (state_q)
            IDLE: begin
                oclk_d = 1'b0;
                if (cfg_valid) begin
                    div_d   = cfg_div;
                    burst_d = cfg_burst;
                end
                if (start) begin
                    d_new   = eff(cfg_valid ? cfg_div : div_q);
                    state_d = RUN;
                    cnt_d   = '0;
                    tcnt_d  = '0;
                    if (d_new == DIV_W'(1)) begin
                        tick_d = 1'b1;
                        tcnt_d = BURST_W'(1);
                        oclk_d = 1'b1;
                    end
                end
            end
            RUN: begin
                last = tick_q && (burst_q != '0) && (tcnt_q == burst_q);
                if (stop) begin
                    state_d = IDLE;
                    oclk_d  = 1'b0;
                    cnt_d   = '0;
                end else if (last) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    if (cnt_q == d_run - DIV_W'(1)) cnt_d = '0;
                    else cnt_d = cnt_q + DIV_W'(1);
                    if (cnt_d == d_run - DIV_W'(1)) begin
                        tick_d = 1'b1;
                        tcnt_d = tcnt_q + BURST_W'(1);
                        oclk_d = ~oclk_q;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                oclk_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Configuration, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q   <= DIV_W'(DEFAULT_DIV);
            burst_q <= '0;
            cnt_q   <= '0;
            tcnt_q  <= '0;
            tick_q  <= 1'b0;
            oclk_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            div_q   <= div_d;
            burst_q <= burst_d;
            cnt_q   <= cnt_d;
            tcnt_q  <= tcnt_d;
            tick_q  <= tick_d;
            oclk_q  <= oclk_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_freq_divide_ctrl.sv
// tb_freq_divide_ctrl: directed plus randomized runs checked against
// an arithmetic model (tick when k%D==0, count k/D, wave (k/D)%2).
module tb_freq_divide_ctrl;

    logic        clk;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [23:0] cfg_div;
    logic [15:0] cfg_burst;
    logic        start;
    logic        stop;
    logic        tick;
    logic        out_clk;
    logic [15:0] tick_cnt;
    logic        busy;
    logic        done;

    int n_assert = 0;
    int n_fail   = 0;
    int m_div    = 2;
    int m_burst  = 0;
    int m_tcnt   = 0;

    freq_divide_ctrl #(
        .DIV_W(24),
        .BURST_W(16),
        .DEFAULT_DIV(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_div(cfg_div),
        .cfg_burst(cfg_burst),
        .start(start),
        .stop(stop),
        .tick(tick),
        .out_clk(out_clk),
        .tick_cnt(tick_cnt),
        .busy(busy),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic outs(input string ph, input int k, input int t,
                        input int o, input int c, input int b,
                        input int d, input int r);
        chk($sformatf("%s k=%0d tick", ph, k), {31'b0, tick}, t);
        chk($sformatf("%s k=%0d out_clk", ph, k), {31'b0, out_clk}, o);
        chk($sformatf("%s k=%0d tick_cnt", ph, k), {16'b0, tick_cnt}, c);
        chk($sformatf("%s k=%0d busy", ph, k), {31'b0, busy}, b);
        chk($sformatf("%s k=%0d done", ph, k), {31'b0, done}, d);
        chk($sformatf("%s k=%0d cfg_ready", ph, k), {31'b0, cfg_ready}, r);
    endtask

    task automatic cfg_step(input int d, input int b);
        cfg_valid = 1'b1;
        cfg_div   = 24'(d);
        cfg_burst = 16'(b);
        @(negedge clk);
        cfg_valid = 1'b0;
        m_div     = d;
        m_burst   = b;
        outs("cfg", 0, 0, 0, m_tcnt, 0, 0, 1);
    endtask

    // Called at a negedge in IDLE; k counts RUN cycles after start.
    task automatic do_run(input bit use_cfg, input int d, input int b,
                          input int stop_k, input int pd, input int pb);
        int dd;
        int bb;
        if (use_cfg) begin
            m_div     = d;
            m_burst   = b;
            cfg_valid = 1'b1;
            cfg_div   = 24'(d);
            cfg_burst = 16'(b);
        end
        dd    = (m_div == 0) ? 1 : m_div;
        bb    = m_burst;
        start = 1'b1;
        for (int k = 1; k <= 3000; k++) begin
            @(negedge clk);
            start     = 1'b0;
            stop      = 1'b0;
            cfg_valid = 1'b0;
            if (stop_k > 0 && k == stop_k + 1) begin
                m_tcnt = (stop_k / dd) % 65536;
                outs("stopped", k, 0, 0, m_tcnt, 0, 0, 1);
                if (pd != 0) begin
                    cfg_valid = 1'b1;
                    m_div     = pd;
                    m_burst   = pb;
                end
                return;
            end
            if (bb != 0 && k == bb * dd + 1) begin
                outs("done", k, 0, bb % 2, bb, 1, 1, 0);
                stop = 1'b1;
                @(negedge clk);
                stop   = 1'b0;
                m_tcnt = bb;
                outs("after", k, 0, 0, bb, 0, 0, 1);
                return;
            end
            outs("run", k, (k % dd == 0) ? 1 : 0, (k / dd) % 2,
                 (k / dd) % 65536, 1, 0, 0);
            if (pd != 0) begin
                cfg_valid = 1'b1;
                cfg_div   = 24'(pd);
                cfg_burst = 16'(pb);
            end
            if (k == stop_k) stop = 1'b1;
        end
        chk("run bound expired", 1, 0);
    endtask

    initial begin
        int d;
        int b;
        int dd;
        int sk;
        rst       = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        cfg_burst = '0;
        start     = 1'b0;
        stop      = 1'b0;
        @(negedge clk);
        outs("reset", 0, 0, 0, 0, 0, 0, 1);
        rst = 1'b1;
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        outs("idle stop", 0, 0, 0, 0, 0, 0, 1);

        do_run(1'b0, 0, 0, 21, 0, 0);

        cfg_step(5, 3);
        do_run(1'b0, 0, 0, 0, 0, 0);

        do_run(1'b1, 0, 4, 0, 0, 0);

        do_run(1'b1, 3, 0, 5, 7, 2);
        do_run(1'b0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 12; i++) begin
            d  = $urandom_range(0, 6);
            b  = $urandom_range(0, 5);
            dd = (d == 0) ? 1 : d;
            if (b == 0) sk = $urandom_range(1, 3 * dd + 2);
            else if ($urandom_range(0, 1) == 1) sk = $urandom_range(1, b * dd);
            else sk = 0;
            if ($urandom_range(0, 1) == 1) begin
                cfg_step(d, b);
                do_run(1'b0, 0, 0, sk, 0, 0);
            end else begin
                do_run(1'b1, d, b, sk, 0, 0);
            end
        end

        cfg_valid = 1'b1;
        cfg_div   = 24'd4;
        cfg_burst = 16'd10;
        start     = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        start     = 1'b0;
        repeat (6) @(negedge clk);
        outs("pre-rst", 7, 0, 1, 1, 1, 0, 0);
        #2 rst = 1'b0;
        #1 outs("async rst", 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        rst     = 1'b1;
        m_div   = 2;
        m_burst = 0;
        m_tcnt  = 0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            outs("post-rst", j, 0, 0, 0, 0, 0, 1);
        end
        do_run(1'b0, 0, 0, 7, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/freq_divide_ctrl.md
Name: freq_divide_ctrl

Overview:
- Programmable clock-enable sequencer for the divider datapath.
- Holds a run-time divisor and burst length, loaded through a valid/ready configuration handshake.
- On start, emits one-cycle tick enables every DIV cycles plus a derived square wave, for a fixed burst or continuously.
- Sits between the control logic and downstream logic that consumes slowed-down clock enables.

Parameters:
- DIV_W, 24, width of the divisor register and period counter.
- BURST_W, 16, width of the burst length and tick counter.
- DEFAULT_DIV, 2, divisor value after reset.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous active-low reset.
- cfg_valid  input  1  configuration offer.
- cfg_ready  output  1  high when configuration is accepted (IDLE only).
- cfg_div  input  DIV_W  requested divisor (period in clk cycles).
- cfg_burst  input  BURST_W  ticks per run; 0 = continuous.
- start  input  1  level-sampled run request.
- stop  input  1  abort request.
- tick  output  1  one-cycle enable at each period boundary.
- out_clk  output  1  square wave, toggles on every tick.
- tick_cnt  output  BURST_W  ticks issued in the current run.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse when a burst completes.

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous, active-low.
- Reset values (rst low): state=IDLE, div_q=DEFAULT_DIV, burst_q=0, period counter=0, tick=0, out_clk=0, tick_cnt=0, done=0, busy=0. Reset mid-run aborts immediately; no tick or done is emitted.
- States: IDLE, RUN, DONE. Encoding is free.
- IDLE:
  - cfg_ready=1.
  - cfg_valid&cfg_ready: div_q<=cfg_div and burst_q<=cfg_burst, effective next cycle.
  - start: go to RUN, counter<=0, tick_cnt<=0, out_clk<=0.
  - cfg_valid and start in the same cycle: the config is loaded and the run starts with the NEW values.
  - stop in IDLE is ignored.
- Effective divisor: D = (div_q==0) ? 1 : div_q.
- RUN:
  - cfg_ready=0; cfg_valid is ignored and stays pending for the requester.
  - Each cycle: if counter==D-1 then tick=1, counter<=0, out_clk<=~out_clk, tick_cnt<=tick_cnt+1; else counter<=counter+1.
  - Timing: the first tick is asserted D cycles after the cycle start was sampled; ticks then repeat every D cycles. With D=1, tick stays high every RUN cycle.
  - burst_q!=0 and the tick being issued makes tick_cnt+1==burst_q: go to DONE next cycle.
  - burst_q==0: run forever. tick_cnt wraps modulo 2^BURST_W with no other effect.
  - stop has priority over the tick and burst end. The cycle stop is high, tick is forced 0, tick_cnt is not incremented, and state returns to IDLE. done is not pulsed; out_clk<=0.
- DONE:
  - Lasts exactly one cycle: done=1, tick=0; then IDLE.
  - tick_cnt holds the final count (==burst_q) until the next start.
  - out_clk holds its value through DONE, then clears to 0 in IDLE.
  - stop in DONE is ignored.
  - start is only sampled in IDLE, so back-to-back bursts have at least one IDLE cycle between them.
- Outputs and timing: tick, done and out_clk are registered outputs (no combinational path from inputs). busy is high in RUN and DONE.
- Widths:
  - counter compare is DIV_W wide.
  - D-1 is computed in DIV_W bits; D>=1 guarantees no underflow.
  - Max period 2^DIV_W-1 cycles.

Test Plan:
- Reset then start with no config (DEFAULT_DIV=2, burst 0) -> tick on every 2nd cycle, out_clk period 4 cycles, busy=1, done never asserted over 20 cycles.
- Config div=5, burst=3, then start -> ticks at cycles 5, 10, 15 after start. tick_cnt reads 1, 2, 3. done pulses once at cycle 16, then IDLE with cycle-16 busy=1 and cycle-17 busy=0. tick_cnt=3 held.
- Config div=0, burst=4 -> treated as D=1. tick high 4 consecutive cycles, then done pulse, then IDLE.
- Config div=3, burst=0, start; assert stop in the same cycle as the 2nd tick boundary -> no 2nd tick, tick_cnt=1, done=0, out_clk=0, IDLE next cycle.
- During RUN, drive cfg_valid with div=7 -> cfg_ready=0, div unchanged. After stop, the pending cfg is accepted in the first IDLE cycle. The next run ticks every 7 cycles.
- Assert rst low asynchronously between clock edges mid-burst (div=4, burst=10) -> all outputs 0 immediately, div_q back to 2. After rst high, no tick until a new start.
